// File: rtl/disp_scan_ctrl.sv
// ============================================================================
// Module      : disp_scan_ctrl
// Description : Eight-digit multiplexed display scan controller with
//               per-slot blanking, blink, and frame-coherent update handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module disp_scan_ctrl #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [31:0] upd_hexs,
    input  logic [7:0]  upd_point,
    input  logic [7:0]  upd_les,
    output logic [2:0]  Scan,
    output logic [31:0] Hexs,
    output logic [7:0]  point,
    output logic [7:0]  LES,
    output logic        blank,
    output logic        blink_phase,
    output logic        frame_done
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DIV_W-1:0] c_div_max   = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] c_blank_cyc = DIV_W'(BLANK_CYC);
    localparam logic [FRM_W-1:0] c_frm_max   = FRM_W'(BLINK_FRAMES - 1);
    localparam logic             c_has_blank = (BLANK_CYC != 0);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    localparam state_t c_st_rst = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [DIV_W-1:0]   r_div_cnt;
    logic [2:0]         r_scan;
    logic [FRM_W-1:0]   r_frm_cnt;
    logic               r_blink;
    logic               r_frame_done;
    logic               r_blank;
    logic [31:0]        r_hexs;
    logic [7:0]         r_point;
    logic [7:0]         r_les;
    logic               r_pend_valid;
    logic [31:0]        r_pend_hexs;
    logic [7:0]         r_pend_point;
    logic [7:0]         r_pend_les;
    logic               r_commit;

    logic               w_slot_wrap;
    logic               w_frame_wrap;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [2:0]         w_scan_nxt;
    logic               w_blink_nxt;
    logic               w_commit;
    logic [7:0]         w_les_nxt;
    logic               w_capture;
    logic               w_blank_nxt;

    assign w_slot_wrap  = (r_div_cnt == c_div_max);
    assign w_frame_wrap = w_slot_wrap && (r_scan == 3'd7);
    assign w_div_nxt    = w_slot_wrap ? '0 : r_div_cnt + 1'b1;
    assign w_scan_nxt   = w_slot_wrap ? r_scan + 3'd1 : r_scan;
    assign w_blink_nxt  = (w_frame_wrap && (r_frm_cnt == c_frm_max)) ? ~r_blink : r_blink;
    assign w_commit     = w_frame_wrap && r_pend_valid;
    assign w_les_nxt    = w_commit ? r_pend_les : r_les;
    assign w_capture    = upd_valid && !r_pend_valid;

    // The committed snapshot lands on the same edge as the frame wrap, so
    // blank is computed from the values that will be live next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_blank_nxt = 1'b1;
        case (r_state)
            ST_BLANK: if (w_div_nxt == c_blank_cyc) w_state_nxt = ST_SHOW;
            ST_SHOW:  if (w_slot_wrap && c_has_blank) w_state_nxt = ST_BLANK;
            default:  w_state_nxt = c_st_rst;
        endcase
        w_blank_nxt = (w_state_nxt == ST_BLANK) || (w_blink_nxt && w_les_nxt[w_scan_nxt]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_rst;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt    <= '0;
            r_scan       <= 3'd0;
            r_frm_cnt    <= '0;
            r_blink      <= 1'b0;
            r_frame_done <= 1'b0;
            r_blank      <= 1'b1;
            r_hexs       <= 32'h0;
            r_point      <= 8'hFF;
            r_les        <= 8'h00;
            r_commit     <= 1'b0;
        end else begin
            r_div_cnt    <= w_div_nxt;
            r_scan       <= w_scan_nxt;
            r_blink      <= w_blink_nxt;
            r_frame_done <= w_frame_wrap;
            r_blank      <= w_blank_nxt;
            r_commit     <= w_commit;
            if (w_frame_wrap) begin
                r_frm_cnt <= (r_frm_cnt == c_frm_max) ? '0 : r_frm_cnt + 1'b1;
            end
            if (w_commit) begin
                r_hexs  <= r_pend_hexs;
                r_point <= r_pend_point;
                r_les   <= r_pend_les;
            end
        end
    end

    // The buffer stays full through the frame_done cycle after a commit,
    // so a requester can only refill it once the new frame is underway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_hexs  <= 32'h0;
            r_pend_point <= 8'h00;
            r_pend_les   <= 8'h00;
        end else if (w_capture) begin
            r_pend_valid <= 1'b1;
            r_pend_hexs  <= upd_hexs;
            r_pend_point <= upd_point;
            r_pend_les   <= upd_les;
        end else if (r_commit) begin
            r_pend_valid <= 1'b0;
        end
    end

    assign upd_ready   = !r_pend_valid;
    assign Scan        = r_scan;
    assign Hexs        = r_hexs;
    assign point       = r_point;
    assign LES         = r_les;
    assign blank       = r_blank;
    assign blink_phase = r_blink;
    assign frame_done  = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
// ============================================================================
// Module      : tb_disp_scan_ctrl
// Description : Directed self-checking bench for disp_scan_ctrl (8/2/2 config).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_disp_scan_ctrl;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        upd_valid = 1'b0;
    logic        upd_ready;
    logic [31:0] upd_hexs = 32'h0;
    logic [7:0]  upd_point = 8'h0;
    logic [7:0]  upd_les = 8'h0;
    logic [2:0]  Scan;
    logic [31:0] Hexs;
    logic [7:0]  point;
    logic [7:0]  LES;
    logic        blank;
    logic        blink_phase;
    logic        frame_done;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    disp_scan_ctrl #(
        .SCAN_DIV     (SD),
        .BLANK_CYC    (BC),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_hexs    (upd_hexs),
        .upd_point   (upd_point),
        .upd_les     (upd_les),
        .Scan        (Scan),
        .Hexs        (Hexs),
        .point       (point),
        .LES         (LES),
        .blank       (blank),
        .blink_phase (blink_phase),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #60000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (Scan !== 3'd0 || blank !== 1'b1 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_scan: Scan=%0d blank=%b frame_done=%b, want 0 1 0", Scan, blank, frame_done);
        end
        vectors++;
        if (Hexs !== 32'h0 || point !== 8'hFF || LES !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data: Hexs=%h point=%h LES=%h, want 0 ff 00", Hexs, point, LES);
        end
        vectors++;
        if (blink_phase !== 1'b0 || upd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ctrl: blink_phase=%b upd_ready=%b, want 0 1", blink_phase, upd_ready);
        end
    endtask

    // Releases reset and walks the first full frame up to the frame_done cycle.
    task automatic test_scan();
        logic [2:0] exp_scan;
        logic       exp_blank;
        logic       exp_fd;
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k <= 64; k++) begin
            exp_scan  = 3'((k / SD) % 8);
            exp_blank = ((k % SD) < BC);
            exp_fd    = (k == 64);
            vectors++;
            if (Scan !== exp_scan || blank !== exp_blank || frame_done !== exp_fd || blink_phase !== 1'b0) begin
                miscompares++;
                $display("FAIL scan_seq cyc=%0d: Scan=%0d blank=%b fd=%b blink=%b, want %0d %b %b 0",
                         k, Scan, blank, frame_done, blink_phase, exp_scan, exp_blank, exp_fd);
            end
            if (k < 64) step();
        end
    endtask

    task automatic test_capture_at_frame_done();
        vectors++;
        if (upd_ready !== 1'b1 || frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL fd_capture_pre: upd_ready=%b frame_done=%b, want 1 1", upd_ready, frame_done);
        end
        upd_valid = 1'b1;
        upd_hexs  = 32'hA1B2C3D4;
        upd_point = 8'h3C;
        upd_les   = 8'h00;
        step();
        upd_valid = 1'b0;
        vectors++;
        if (upd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fd_capture_ready: upd_ready=%b, want 0", upd_ready);
        end
        while (cyc < 128) begin
            vectors++;
            if (Hexs !== 32'h0 || point !== 8'hFF) begin
                miscompares++;
                $display("FAIL fd_capture_hold cyc=%0d: Hexs=%h point=%h, want 0 ff", cyc, Hexs, point);
            end
            step();
        end
        vectors++;
        if (Hexs !== 32'hA1B2C3D4 || point !== 8'h3C || frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL fd_capture_commit: Hexs=%h point=%h fd=%b, want a1b2c3d4 3c 1", Hexs, point, frame_done);
        end
        step();
        vectors++;
        if (upd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fd_capture_release: upd_ready=%b, want 1", upd_ready);
        end
    endtask

    task automatic test_update();
        while (cyc < 150) step();
        vectors++;
        if (upd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL upd_ready_pre: upd_ready=%b, want 1", upd_ready);
        end
        upd_valid = 1'b1;
        upd_hexs  = 32'h76543210;
        upd_point = 8'h5A;
        upd_les   = 8'h05;
        step();
        upd_valid = 1'b0;
        while (cyc < 192) begin
            vectors++;
            if (upd_ready !== 1'b0 || Hexs !== 32'hA1B2C3D4 || LES !== 8'h00) begin
                miscompares++;
                $display("FAIL upd_hold cyc=%0d: ready=%b Hexs=%h LES=%h, want 0 a1b2c3d4 00", cyc, upd_ready, Hexs, LES);
            end
            step();
        end
        vectors++;
        if (Hexs !== 32'h76543210 || point !== 8'h5A || LES !== 8'h05 || upd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL upd_commit: Hexs=%h point=%h LES=%h ready=%b, want 76543210 5a 05 0",
                     Hexs, point, LES, upd_ready);
        end
        step();
        vectors++;
        if (upd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL upd_release: upd_ready=%b, want 1", upd_ready);
        end
    endtask

    // Blink toggles every two frames; LES=05 darkens slots 0 and 2 while it is high.
    task automatic test_blink();
        logic [7:0] exp_les;
        logic [2:0] exp_scan;
        logic       exp_blink;
        logic       exp_blank;
        logic       exp_fd;
        exp_les = 8'h05;
        while (cyc <= 330) begin
            exp_scan  = 3'((cyc / SD) % 8);
            exp_blink = (((cyc / 128) % 2) == 1);
            exp_blank = ((cyc % SD) < BC) || (exp_blink && exp_les[exp_scan]);
            exp_fd    = ((cyc % 64) == 0);
            vectors++;
            if (Scan !== exp_scan || blink_phase !== exp_blink || blank !== exp_blank || frame_done !== exp_fd) begin
                miscompares++;
                $display("FAIL blink cyc=%0d: Scan=%0d blink=%b blank=%b fd=%b, want %0d %b %b %b",
                         cyc, Scan, blink_phase, blank, frame_done, exp_scan, exp_blink, exp_blank, exp_fd);
            end
            if (cyc < 330) step();
            else break;
        end
    endtask

    task automatic test_back_to_back();
        upd_valid = 1'b1;
        upd_hexs  = 32'h11111111;
        upd_point = 8'h11;
        upd_les   = 8'h00;
        step();
        upd_hexs  = 32'h22222222;
        upd_point = 8'h22;
        while (cyc < 384) begin
            vectors++;
            if (upd_ready !== 1'b0 || Hexs !== 32'h76543210) begin
                miscompares++;
                $display("FAIL b2b_full cyc=%0d: ready=%b Hexs=%h, want 0 76543210", cyc, upd_ready, Hexs);
            end
            step();
        end
        vectors++;
        if (Hexs !== 32'h11111111 || point !== 8'h11 || upd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_commit1: Hexs=%h point=%h ready=%b, want 11111111 11 0", Hexs, point, upd_ready);
        end
        step();
        vectors++;
        if (upd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_reopen: upd_ready=%b, want 1", upd_ready);
        end
        step();
        upd_valid = 1'b0;
        vectors++;
        if (upd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept2: upd_ready=%b, want 0", upd_ready);
        end
        while (cyc < 448) begin
            vectors++;
            if (Hexs !== 32'h11111111) begin
                miscompares++;
                $display("FAIL b2b_hold cyc=%0d: Hexs=%h, want 11111111", cyc, Hexs);
            end
            step();
        end
        vectors++;
        if (Hexs !== 32'h22222222 || point !== 8'h22) begin
            miscompares++;
            $display("FAIL b2b_commit2: Hexs=%h point=%h, want 22222222 22", Hexs, point);
        end
    endtask

    task automatic test_async_reset();
        logic [2:0] exp_scan;
        logic       exp_blank;
        logic       exp_fd;
        while (cyc < 460) step();
        upd_valid = 1'b1;
        upd_hexs  = 32'hDEADBEEF;
        upd_point = 8'h00;
        upd_les   = 8'hFF;
        step();
        upd_valid = 1'b0;
        while (cyc < 491) step();
        vectors++;
        if (Scan !== 3'd5 || upd_ready !== 1'b0 || blink_phase !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre: Scan=%0d ready=%b blink=%b, want 5 0 1", Scan, upd_ready, blink_phase);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (Scan !== 3'd0 || blank !== 1'b1 || frame_done !== 1'b0 || blink_phase !== 1'b0 || upd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_ctrl: Scan=%0d blank=%b fd=%b blink=%b ready=%b, want 0 1 0 0 1",
                     Scan, blank, frame_done, blink_phase, upd_ready);
        end
        vectors++;
        if (Hexs !== 32'h0 || point !== 8'hFF || LES !== 8'h00) begin
            miscompares++;
            $display("FAIL areset_data: Hexs=%h point=%h LES=%h, want 0 ff 00", Hexs, point, LES);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int k = 0; k <= 65; k++) begin
            exp_scan  = 3'((k / SD) % 8);
            exp_blank = ((k % SD) < BC);
            exp_fd    = (k == 64);
            vectors++;
            if (Scan !== exp_scan || blank !== exp_blank || frame_done !== exp_fd ||
                Hexs !== 32'h0 || LES !== 8'h00 || point !== 8'hFF || upd_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL areset_after cyc=%0d: Scan=%0d blank=%b fd=%b Hexs=%h LES=%h point=%h ready=%b",
                         k, Scan, blank, frame_done, Hexs, LES, point, upd_ready);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_capture_at_frame_done();
        test_update();
        test_blink();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter BLANK_CYC, default 500, blanking cycles at start of each slot; legal range 0..SCAN_DIV-1.
REQ-003 Parameter BLINK_FRAMES, default 32, full scan frames per blink half-period; legal range ≥1.
REQ-004 clk  in  1  system clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 upd_valid  in  1  requester offers new display contents.
REQ-007 upd_ready  out  1  controller can accept new contents.
REQ-008 upd_hexs  in  32  eight 4-bit digit codes, digit k in bits [4k+3:4k].
REQ-009 upd_point  in  8  per-digit decimal-point bits, passed through unmodified.
REQ-010 upd_les  in  8  per-digit blink-enable mask.
REQ-011 Scan  out  3  current digit index feeding the digit multiplexer.
REQ-012 Hexs  out  32  committed digit codes.
REQ-013 point  out  8  committed decimal-point bits.
REQ-014 LES  out  8  committed blink mask.
REQ-015 blank  out  1  1 = downstream forces all anodes off.
REQ-016 blink_phase  out  1  current blink half-period (1 = blinking digits dark).
REQ-017 frame_done  out  1  one-cycle pulse at each frame wrap.

Function
REQ-018 Slot counter div_cnt SHALL count 0..SCAN_DIV-1, wrapping to 0; at wrap, Scan SHALL increment modulo 8 (7 -> 0).
REQ-019 State machine SHALL have two states: BLANK (div_cnt < BLANK_CYC) and SHOW (otherwise); with BLANK_CYC=0, BLANK is never entered.
REQ-020 blank SHALL be registered and equal 1 in BLANK, or in SHOW when blink_phase=1 and LES[Scan]=1; otherwise 0.
REQ-021 frame_done SHALL pulse high for exactly one cycle, in the cycle after Scan changes 7 -> 0.
REQ-022 A frame counter SHALL count frame_done pulses 0..BLINK_FRAMES-1; at its wrap, blink_phase SHALL toggle in the same cycle as frame_done.
REQ-023 The handshake SHALL complete when upd_valid=1 and upd_ready=1 on a rising edge; upd_hexs/upd_point/upd_les are then captured into a single-entry pending buffer.
REQ-024 upd_ready SHALL be 1 exactly when the pending buffer is empty; it SHALL fall the cycle after a capture.
REQ-025 Pending contents SHALL be copied to Hexs/point/LES in the frame_done cycle; the buffer SHALL then empty, and upd_ready SHALL rise the following cycle.
REQ-026 A capture in the same cycle as frame_done SHALL be stored as pending and committed at the next frame, not the current one.
REQ-027 Hexs/point/LES SHALL never change except at frame_done, so each frame displays one coherent snapshot.
REQ-028 upd_valid held with upd_ready=0 SHALL have no effect; the requester keeps data stable until acceptance.

Reset
REQ-029 Asserting rst_n=0 at any time, including mid-slot or with data pending, SHALL immediately force Scan=0, div_cnt=0, blank=1, Hexs=0, point=8'hFF, LES=0, blink_phase=0, frame_done=0, frame counter=0, pending empty, and upd_ready=1.
REQ-030 After release, the first slot SHALL start at div_cnt=0 in BLANK (or SHOW if BLANK_CYC=0).

Verification (SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-031 Release reset, idle 64 cycles -> Scan steps 0..7 every 8 cycles, blank=1 for 2 cycles per slot, and frame_done pulses once at cycle 64.
REQ-032 Offer upd_hexs=32'h76543210 mid-frame -> upd_ready drops the next cycle; Hexs stays 0 until frame_done, then becomes 32'h76543210; upd_ready returns high 1 cycle later.
REQ-033 Assert upd_valid in the frame_done cycle with an empty buffer -> data is captured but Hexs updates only at the following frame_done.
REQ-034 Set upd_les=8'h05 and run 4 frames -> blink_phase toggles every 2 frames; while blink_phase=1, blank=1 for all of slots 0 and 2, and normal blanking applies elsewhere.
REQ-035 Apply rst_n=0 at Scan=5, div_cnt=3 with data pending -> all outputs take their reset values asynchronously; the pending data is discarded and never appears on Hexs.
REQ-036 Hold upd_valid=1 with new data while the buffer is full -> no overwrite; the held data is accepted only after the next commit.
